// File: rtl/weight_update_pkg.sv
// Shared numeric defaults, FSM state encoding and the saturation helper
// for the weight-update datapath.
package nn_pkg;

  localparam int DATA_SIZE = 16;
  localparam int FRAC_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_SIZE-1:0] value;
    logic                 ovf;
  } sat_t;

  // A wide value fits when every bit from the data sign position upward agrees.
  function automatic sat_t sat_to_data(input logic [2*DATA_SIZE:0] x);
    sat_t               r;
    logic [DATA_SIZE+1:0] hi;
    hi = x[2*DATA_SIZE:DATA_SIZE-1];
    if ((&hi) || !(|hi)) begin
      r.value = x[DATA_SIZE-1:0];
      r.ovf   = 1'b0;
    end else if (x[2*DATA_SIZE]) begin
      r.value = {1'b1, {(DATA_SIZE-1){1'b0}}};
      r.ovf   = 1'b1;
    end else begin
      r.value = {1'b0, {(DATA_SIZE-1){1'b1}}};
      r.ovf   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/weight_update_if.sv
// Operand/result handshake bundle between the derivative stage, the weight
// update block and its consumer.
interface weight_update_if #(
  parameter int SIZE          = 3,
  parameter int DATA_SIZE     = nn_pkg::DATA_SIZE,
  parameter int LR_SHIFT_SIZE = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [SIZE*DATA_SIZE-1:0]   weight;
  logic [SIZE*DATA_SIZE-1:0]   diff_cost;
  logic [SIZE*DATA_SIZE-1:0]   diff_start;
  logic [LR_SHIFT_SIZE-1:0]    lr_shift;
  logic                        out_valid;
  logic                        out_ready;
  logic [SIZE*DATA_SIZE-1:0]   weight_out;
  logic                        sat_flag;

  modport master (
    output in_valid, weight, diff_cost, diff_start, lr_shift, out_ready,
    input  in_ready, out_valid, weight_out, sat_flag
  );

  modport slave (
    input  in_valid, weight, diff_cost, diff_start, lr_shift, out_ready,
    output in_ready, out_valid, weight_out, sat_flag
  );
endinterface

// File: rtl/weight_update_grad_step.sv
// One element of the update: w - ((dc*ds) >>> FRAC_BITS >>> lr_shift),
// clamped back to the data width.
module grad_step
  import nn_pkg::*;
#(
  parameter int DATA_SIZE     = nn_pkg::DATA_SIZE,
  parameter int FRAC_BITS     = nn_pkg::FRAC_BITS,
  parameter int LR_SHIFT_SIZE = 4
) (
  input  logic [DATA_SIZE-1:0]     w,
  input  logic [DATA_SIZE-1:0]     dc,
  input  logic [DATA_SIZE-1:0]     ds,
  input  logic [LR_SHIFT_SIZE-1:0] lr_shift,
  output logic [DATA_SIZE-1:0]     w_new,
  output logic                     sat
);

  logic signed [2*DATA_SIZE-1:0] p_s;
  logic signed [2*DATA_SIZE-1:0] g_s;
  logic signed [2*DATA_SIZE-1:0] d_s;
  logic        [2*DATA_SIZE:0]   w_wide_s;
  sat_t                          r_s;

  // Gradient, learning-rate scaling and saturating subtraction.
  always_comb begin
    p_s      = $signed({{DATA_SIZE{dc[DATA_SIZE-1]}}, dc})
             * $signed({{DATA_SIZE{ds[DATA_SIZE-1]}}, ds});
    g_s      = p_s >>> FRAC_BITS;
    d_s      = g_s >>> lr_shift;
    w_wide_s = {{(DATA_SIZE+1){w[DATA_SIZE-1]}}, w} - {d_s[2*DATA_SIZE-1], d_s};
    r_s      = sat_to_data(w_wide_s);
    w_new    = r_s.value;
    sat      = r_s.ovf;
  end

endmodule

// File: rtl/weight_update.sv
// Sequential weight update: accepts one operand set, walks one element per
// clock through grad_step, then holds the packed result until taken.
module weight_update
  import nn_pkg::*;
#(
  parameter int SIZE          = 3,
  parameter int DATA_SIZE     = nn_pkg::DATA_SIZE,
  parameter int FRAC_BITS     = nn_pkg::FRAC_BITS,
  parameter int LR_SHIFT_SIZE = 4
) (
  input logic            clk,
  input logic            reset,
  weight_update_if.slave bus
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  state_t                     state_r;
  logic [IDX_W-1:0]           idx_r;
  logic [SIZE*DATA_SIZE-1:0]  w_r;
  logic [SIZE*DATA_SIZE-1:0]  dc_r;
  logic [SIZE*DATA_SIZE-1:0]  ds_r;
  logic [LR_SHIFT_SIZE-1:0]   lr_r;
  logic [SIZE*DATA_SIZE-1:0]  result_r;
  logic                       sat_r;
  logic                       in_ready_r;
  logic                       out_valid_r;
  logic [DATA_SIZE-1:0]       w_new_s;
  logic                       sat_s;

  grad_step #(
    .DATA_SIZE    (DATA_SIZE),
    .FRAC_BITS    (FRAC_BITS),
    .LR_SHIFT_SIZE(LR_SHIFT_SIZE)
  ) u_grad_step (
    .w       (w_r [idx_r*DATA_SIZE +: DATA_SIZE]),
    .dc      (dc_r[idx_r*DATA_SIZE +: DATA_SIZE]),
    .ds      (ds_r[idx_r*DATA_SIZE +: DATA_SIZE]),
    .lr_shift(lr_r),
    .w_new   (w_new_s),
    .sat     (sat_s)
  );

  // Control FSM with operand capture and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      w_r         <= '0;
      dc_r        <= '0;
      ds_r        <= '0;
      lr_r        <= '0;
      result_r    <= '0;
      sat_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            w_r        <= bus.weight;
            dc_r       <= bus.diff_cost;
            ds_r       <= bus.diff_start;
            lr_r       <= bus.lr_shift;
            idx_r      <= '0;
            sat_r      <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= CALC;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        CALC: begin
          result_r[idx_r*DATA_SIZE +: DATA_SIZE] <= w_new_s;
          sat_r <= sat_r | sat_s;
          if (idx_r == IDX_W'(SIZE-1)) begin
            idx_r       <= '0;
            out_valid_r <= 1'b1;
            state_r     <= HOLD;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        HOLD: begin
          // No bypass: in_ready returns only once the result has been taken.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.weight_out = result_r;
  assign bus.sat_flag   = sat_r;

endmodule
